// File: rtl/yarp_data_mem.sv
// Data-memory responder for the yarp load/store port: one request at a time,
// programmable wait states, byte/half/word access to a word-organised array.
module yarp_data_mem #(
    parameter int unsigned MEM_DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_wr_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned AW = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam int unsigned CW = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic            wr_q, wr_d;
    logic [1:0]      size_q, size_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            req_ready_d;
    logic            rsp_valid_d;
    logic [31:0]     rsp_rdata_d;
    logic            rsp_err_d;

    logic [31:0]     mem [MEM_DEPTH_WORDS];

    logic [AW-1:0]   idx_c;
    logic            idx_oob_c;
    logic            size_err_c;
    logic            acc_err_c;
    logic [3:0]      be_c;
    logic [31:0]     wdata_rep_c;
    logic [31:0]     rd_word_c;
    logic [31:0]     rd_shift_c;
    logic [31:0]     load_data_c;
    logic            mem_we_c;

    // Address decode, alignment checks and lane steering for the captured request
    always_comb begin
        idx_c       = addr_q[AW+1:2];
        idx_oob_c   = ({2'b00, addr_q[31:2]} >= 32'(MEM_DEPTH_WORDS));
        size_err_c  = 1'b1;
        be_c        = 4'b0000;
        wdata_rep_c = wdata_q;
        rd_word_c   = idx_oob_c ? 32'h0 : mem[idx_c];
        rd_shift_c  = rd_word_c >> {addr_q[1:0], 3'b000};
        load_data_c = 32'h0;
        unique case (size_q)
            SZ_BYTE: begin
                size_err_c  = 1'b0;
                be_c        = 4'(4'b0001 << addr_q[1:0]);
                wdata_rep_c = {4{wdata_q[7:0]}};
                load_data_c = {24'h0, rd_shift_c[7:0]};
            end
            SZ_HALF: begin
                size_err_c  = addr_q[0];
                be_c        = 4'(4'b0011 << addr_q[1:0]);
                wdata_rep_c = {2{wdata_q[15:0]}};
                load_data_c = {16'h0, rd_shift_c[15:0]};
            end
            SZ_WORD: begin
                size_err_c  = |addr_q[1:0];
                be_c        = 4'b1111;
                load_data_c = rd_word_c;
            end
            default: size_err_c = 1'b1;
        endcase
        acc_err_c = size_err_c | idx_oob_c;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_o;
        rsp_valid_d = rsp_valid_o;
        rsp_rdata_d = rsp_rdata_o;
        rsp_err_d   = rsp_err_o;
        mem_we_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid_i) begin
                    addr_d      = req_addr_i;
                    wr_d        = req_wr_i;
                    size_d      = req_size_i;
                    wdata_d     = req_wdata_i;
                    cnt_d       = CW'(WAIT_CYCLES);
                    req_ready_d = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    mem_we_c    = wr_q & ~acc_err_c;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err_c;
                    rsp_rdata_d = (acc_err_c || wr_q) ? 32'h0 : load_data_c;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            wdata_q     <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            req_ready_o <= req_ready_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_rdata_o <= rsp_rdata_d;
            rsp_err_o   <= rsp_err_d;
        end
    end

    // Array is not reset; a reset on the commit edge suppresses the write
    always_ff @(posedge clk) begin
        if (!reset && mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) begin
                    mem[idx_c][8*b +: 8] <= wdata_rep_c[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_yarp_data_mem.sv
// Directed bench for yarp_data_mem: a WAIT_CYCLES=2 instance for access and
// corner cases, and a WAIT_CYCLES=0 instance for back-to-back throughput.
`timescale 1ns/1ps
module tb_yarp_data_mem;

    localparam int unsigned DEPTH = 1024;
    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b11;
    localparam logic [1:0] SX = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0]  req_size;

    logic        req_valid0, req_ready0, req_wr0, rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
    logic [1:0]  req_size0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    yarp_data_mem #(.MEM_DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_wr_i(req_wr), .req_size_i(req_size), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    yarp_data_mem #(.MEM_DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_addr_i(req_addr0),
        .req_wr_i(req_wr0), .req_size_i(req_size0), .req_wdata_i(req_wdata0),
        .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0),
        .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction on the WAIT_CYCLES=2 instance; inputs are scrambled after acceptance
    task automatic xact(input logic [31:0] a, input logic w, input logic [1:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output logic e,
                        output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_wr = w; req_size = s; req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = ~a; req_wr = ~w; req_size = ~s; req_wdata = ~d;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rsp_rdata;
        e  = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    vec_t        vecs [18];
    logic [31:0] rd, held;
    logic        e;
    int          lat;

    initial begin
        vecs[0]  = '{32'h10,   1'b1, SW, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{32'h10,   1'b0, SW, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{32'h12,   1'b1, SB, 32'h00000055, 32'h0,        1'b0};
        vecs[3]  = '{32'h10,   1'b0, SW, 32'h0,        32'hDE55BEEF, 1'b0};
        vecs[4]  = '{32'h13,   1'b0, SB, 32'h0,        32'h000000DE, 1'b0};
        vecs[5]  = '{32'h12,   1'b0, SH, 32'h0,        32'h0000DE55, 1'b0};
        vecs[6]  = '{32'h11,   1'b1, SH, 32'h0000A5A5, 32'h0,        1'b1};
        vecs[7]  = '{32'h10,   1'b0, SW, 32'h0,        32'hDE55BEEF, 1'b0};
        vecs[8]  = '{32'h0E,   1'b0, SW, 32'h0,        32'h0,        1'b1};
        vecs[9]  = '{32'h10,   1'b0, SX, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{32'h10,   1'b1, SX, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[11] = '{32'h10,   1'b0, SW, 32'h0,        32'hDE55BEEF, 1'b0};
        vecs[12] = '{32'h12,   1'b1, SH, 32'hFFFF1234, 32'h0,        1'b0};
        vecs[13] = '{32'h10,   1'b1, SB, 32'hFFFFFFAB, 32'h0,        1'b0};
        vecs[14] = '{32'h10,   1'b0, SW, 32'h0,        32'h1234BEAB, 1'b0};
        vecs[15] = '{32'hFFC,  1'b1, SW, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[16] = '{32'hFFE,  1'b0, SH, 32'h0,        32'h0000CAFE, 1'b0};
        vecs[17] = '{32'h1000, 1'b0, SW, 32'h0,        32'h0,        1'b1};

        reset = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_wr = 1'b0; req_size = SW; req_wdata = '0;
        rsp_ready = 1'b0;
        req_valid0 = 1'b0; req_addr0 = 32'h8; req_wr0 = 1'b1; req_size0 = SW;
        req_wdata0 = 32'h600DCAFE; rsp_ready0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err",   32'(rsp_err), 32'h0);
        check("rst0_req_ready", 32'(req_ready0), 32'h1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            xact(vecs[i].addr, vecs[i].wr, vecs[i].size, vecs[i].wdata, rd, e, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
        end

        // Out-of-range load with response back-pressure and a competing request held
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'(4 * DEPTH); req_wr = 1'b0; req_size = SW;
        @(posedge clk);
        #1;
        req_addr = 32'h10;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("oob_err", 32'(rsp_err), 32'h1);
        check("oob_rdata", rsp_rdata, 32'h0);
        held = rsp_rdata;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_valid", k), 32'(rsp_valid), 32'h1);
            check($sformatf("hold%0d_rdata", k), rsp_rdata, held);
            check($sformatf("hold%0d_err", k), 32'(rsp_err), 32'h1);
            check($sformatf("hold%0d_req_ready", k), 32'(req_ready), 32'h0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("release_valid", 32'(rsp_valid), 32'h0);
        check("release_req_ready", 32'(req_ready), 32'h1);

        // Reset landing on the commit edge of a store must leave the old word intact
        xact(32'h20, 1'b1, SW, 32'h0BADF00D, rd, e, lat);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h20; req_wr = 1'b1; req_size = SW;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("busy_rst_req_ready", 32'(req_ready), 32'h1);
        check("busy_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        xact(32'h20, 1'b0, SW, 32'h0, rd, e, lat);
        check("busy_rst_word", rd, 32'h0BADF00D);
        check("busy_rst_err", 32'(e), 32'h0);

        // Zero wait states, request always valid, response always accepted
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            req_valid0 = 1'b1;
            req_wr0    = (k < 9);
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d_req_ready", k), 32'(req_ready0), 32'((k % 3) == 2));
            check($sformatf("b2b%0d_rsp_valid", k), 32'(rsp_valid0), 32'((k % 3) == 1));
            if ((k % 3) == 1) begin
                check($sformatf("b2b%0d_rdata", k), rsp_rdata0, (k >= 9) ? 32'h600DCAFE : 32'h0);
                check($sformatf("b2b%0d_err", k), 32'(rsp_err0), 32'h0);
            end
        end
        @(negedge clk);
        req_valid0 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
